// File: rtl/mandel_pkg.sv
// mandel_pkg: types and widths shared by the Mandelbrot pipeline
// (pixel_scheduler and depth_calculator).
package mandel_pkg;

  localparam int COORD_W = 11;
  localparam int DEPTH_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    EMIT  = 2'd3
  } sched_state_t;

  // Highest coordinate value for a line/frame of 'res' pixels.
  function automatic logic [COORD_W-1:0] last_coord(input int res);
    return COORD_W'(res - 1);
  endfunction

endpackage

// File: rtl/pixel_scheduler_if.sv
// pixel_scheduler_if: frame request, calculator handshake and pixel output
// stream of the scan controller. master = scheduler side.
interface pixel_scheduler_if
  import mandel_pkg::*;
#(
  parameter int WORD_LENGTH = 64
);

  // frame request
  logic                   frame_start;
  logic [WORD_LENGTH-1:0] re_origin;
  logic [WORD_LENGTH-1:0] im_origin;
  logic [WORD_LENGTH-1:0] step;

  // calculator side
  logic                   calc_start;
  logic [COORD_W-1:0]     calc_x;
  logic [COORD_W-1:0]     calc_y;
  logic [WORD_LENGTH-1:0] re_c;
  logic [WORD_LENGTH-1:0] im_c;
  logic                   calc_done;
  logic [DEPTH_W-1:0]     calc_depth;

  // pixel output stream
  logic                   pix_valid;
  logic                   pix_ready;
  logic [DEPTH_W-1:0]     pix_depth;
  logic [COORD_W-1:0]     pix_x;
  logic [COORD_W-1:0]     pix_y;
  logic                   pix_sof;
  logic                   pix_eol;

  // status
  logic                   busy;
  logic                   frame_done;

  modport master (
    input  frame_start, re_origin, im_origin, step, calc_done, calc_depth, pix_ready,
    output calc_start, calc_x, calc_y, re_c, im_c,
           pix_valid, pix_depth, pix_x, pix_y, pix_sof, pix_eol, busy, frame_done
  );

  modport slave (
    output frame_start, re_origin, im_origin, step, calc_done, calc_depth, pix_ready,
    input  calc_start, calc_x, calc_y, re_c, im_c,
           pix_valid, pix_depth, pix_x, pix_y, pix_sof, pix_eol, busy, frame_done
  );

endinterface

// File: rtl/coord_stepper.sv
// coord_stepper: raster x/y counters plus the re/im accumulators that track
// the complex constant of the current pixel. Accumulators wrap silently.
module coord_stepper
  import mandel_pkg::*;
#(
  parameter int WORD_LENGTH = 64,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   i_load,
  input  logic                   i_advance,
  input  logic [WORD_LENGTH-1:0] i_re_origin,
  input  logic [WORD_LENGTH-1:0] i_im_origin,
  input  logic [WORD_LENGTH-1:0] i_step,
  output logic [COORD_W-1:0]     o_x,
  output logic [COORD_W-1:0]     o_y,
  output logic [WORD_LENGTH-1:0] o_re,
  output logic [WORD_LENGTH-1:0] o_im,
  output logic                   o_sof,
  output logic                   o_eol,
  output logic                   o_last
);

  localparam logic [COORD_W-1:0] X_LAST = last_coord(H_RES);
  localparam logic [COORD_W-1:0] Y_LAST = last_coord(V_RES);

  logic [COORD_W-1:0]     r_x;
  logic [COORD_W-1:0]     r_y;
  logic [WORD_LENGTH-1:0] r_re;
  logic [WORD_LENGTH-1:0] r_im;
  logic [WORD_LENGTH-1:0] r_re_origin;
  logic [WORD_LENGTH-1:0] r_step;
  logic                   w_eol;

  assign w_eol = (r_x == X_LAST);

  // Load the frame origin, or step one pixel in raster order; the imaginary
  // axis decreases going down, and each new line restarts from the latched
  // real origin.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_re        <= '0;
      r_im        <= '0;
      r_re_origin <= '0;
      r_step      <= '0;
    end else if (i_load) begin
      r_x         <= '0;
      r_y         <= '0;
      r_re        <= i_re_origin;
      r_im        <= i_im_origin;
      r_re_origin <= i_re_origin;
      r_step      <= i_step;
    end else if (i_advance) begin
      if (!w_eol) begin
        r_x  <= r_x + 1'b1;
        r_re <= r_re + r_step;
      end else begin
        r_x  <= '0;
        r_re <= r_re_origin;
        r_y  <= r_y + 1'b1;
        r_im <= r_im - r_step;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_re   = r_re;
  assign o_im   = r_im;
  assign o_sof  = (r_x == '0) && (r_y == '0);
  assign o_eol  = w_eol;
  assign o_last = w_eol && (r_y == Y_LAST);

endmodule

// File: rtl/pixel_scheduler.sv
// pixel_scheduler: walks a frame in raster order, issues one pixel at a time
// to depth_calculator and forwards each depth on a valid/ready stream.
// Build option PIXEL_SCHED_OVERLAP_EN: the output register becomes a
// one-entry buffer so the next pixel is issued while the previous result
// waits for pix_ready. Without it, pixels are handled strictly serially.
module pixel_scheduler
  import mandel_pkg::*;
#(
  parameter int FRAC        = 60,
  parameter int WORD_LENGTH = 64,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480
) (
  input  logic              sysclk,
  input  logic              reset,
  pixel_scheduler_if.master bus
);

  // FRAC only fixes the meaning of the coordinate words; nothing is built
  // from it, but an out-of-range value is flagged by a named empty block.
  if (FRAC < 0 || FRAC >= WORD_LENGTH) begin : g_frac_out_of_range
  end

  sched_state_t r_state;
  sched_state_t w_state_next;

  logic r_wait_seen;
  logic w_load;
  logic w_advance;
  logic w_capture;
  logic w_accept;
  logic w_frame_end;

  logic [COORD_W-1:0]     w_x;
  logic [COORD_W-1:0]     w_y;
  logic [WORD_LENGTH-1:0] w_re;
  logic [WORD_LENGTH-1:0] w_im;
  logic                   w_sof;
  logic                   w_eol;
  logic                   w_last;

  logic               r_pix_valid;
  logic [DEPTH_W-1:0] r_pix_depth;
  logic [COORD_W-1:0] r_pix_x;
  logic [COORD_W-1:0] r_pix_y;
  logic               r_pix_sof;
  logic               r_pix_eol;
  logic               r_pix_last;
  logic               r_busy;
  logic               r_frame_done;

  coord_stepper #(
    .WORD_LENGTH (WORD_LENGTH),
    .H_RES       (H_RES),
    .V_RES       (V_RES)
  ) u_stepper (
    .sysclk      (sysclk),
    .reset       (reset),
    .i_load      (w_load),
    .i_advance   (w_advance),
    .i_re_origin (bus.re_origin),
    .i_im_origin (bus.im_origin),
    .i_step      (bus.step),
    .o_x         (w_x),
    .o_y         (w_y),
    .o_re        (w_re),
    .o_im        (w_im),
    .o_sof       (w_sof),
    .o_eol       (w_eol),
    .o_last      (w_last)
  );

  assign w_accept    = r_pix_valid && bus.pix_ready;
  // Only the final pixel of a frame is ever held in EMIT with r_pix_last set.
  assign w_frame_end = (r_state == EMIT) && w_accept && r_pix_last;

  // State register.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.frame_start) begin
          w_load       = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        w_state_next = WAIT;
      end
      WAIT: begin
        // The first WAIT cycle still shows the previous pixel's done level.
        if (r_wait_seen && bus.calc_done) begin
`ifdef PIXEL_SCHED_OVERLAP_EN
          // done is a held level, so a full buffer just delays the capture.
          if (!r_pix_valid || w_accept) begin
            w_capture = 1'b1;
            if (w_last) begin
              w_state_next = EMIT;
            end else begin
              w_advance    = 1'b1;
              w_state_next = ISSUE;
            end
          end
`else
          w_capture    = 1'b1;
          w_state_next = EMIT;
`endif
        end
      end
      EMIT: begin
        if (w_accept) begin
          if (r_pix_last) begin
            w_state_next = IDLE;
          end else begin
            w_advance    = 1'b1;
            w_state_next = ISSUE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output register, busy/frame_done status and the first-WAIT-cycle marker.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_wait_seen  <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_pix_depth  <= '0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_pix_sof    <= 1'b0;
      r_pix_eol    <= 1'b0;
      r_pix_last   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      r_wait_seen  <= (r_state == WAIT);
      if (w_load) begin
        r_busy <= 1'b1;
      end else if (w_frame_end) begin
        r_busy <= 1'b0;
      end
      if (w_capture) begin
        r_pix_valid <= 1'b1;
        r_pix_depth <= bus.calc_depth;
        r_pix_x     <= w_x;
        r_pix_y     <= w_y;
        r_pix_sof   <= w_sof;
        r_pix_eol   <= w_eol;
        r_pix_last  <= w_last;
      end else if (w_accept) begin
        r_pix_valid <= 1'b0;
      end
    end
  end

  assign bus.calc_start = (r_state == ISSUE);
  assign bus.calc_x     = w_x;
  assign bus.calc_y     = w_y;
  assign bus.re_c       = w_re;
  assign bus.im_c       = w_im;
  assign bus.pix_valid  = r_pix_valid;
  assign bus.pix_depth  = r_pix_depth;
  assign bus.pix_x      = r_pix_x;
  assign bus.pix_y      = r_pix_y;
  assign bus.pix_sof    = r_pix_sof;
  assign bus.pix_eol    = r_pix_eol;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_pixel_scheduler.sv
// tb_pixel_scheduler: 4x2 frames against a behavioural depth_calculator.
// Expected pixels are pushed when calc_start is seen and popped on each
// output handshake.
module tb_pixel_scheduler;
  import mandel_pkg::*;

  localparam int WL   = 64;
  localparam int HR   = 4;
  localparam int VR   = 2;
  localparam int NPIX = HR * VR;
  localparam int LAT  = 4;
`ifdef PIXEL_SCHED_OVERLAP_EN
  localparam int BP_STARTS = 1;
`else
  localparam int BP_STARTS = 0;
`endif

  localparam logic [63:0] NEG2 = 64'hE000_0000_0000_0000;  // -2.0
  localparam logic [63:0] ONE  = 64'h1000_0000_0000_0000;  //  1.0
  localparam logic [63:0] HALF = 64'h0800_0000_0000_0000;  //  0.5
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [9:0]  depth;
    logic        sof;
    logic        eol;
  } exp_pix_t;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  always #5 sysclk = ~sysclk;

  pixel_scheduler_if #(.WORD_LENGTH(WL)) bus_if ();

  pixel_scheduler #(
    .FRAC        (60),
    .WORD_LENGTH (WL),
    .H_RES       (HR),
    .V_RES       (VR)
  ) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  exp_pix_t    sb[$];
  logic [63:0] exp_re0, exp_im0, exp_step;
  int          issue_idx   = 0;
  int          issue_total = 0;
  int          n_out       = 0;
  int          n_fdone     = 0;
  bit          stale_hold  = 0;
  bit          wrap_mode   = 0;
  bit          bp_arm      = 0;
  bit          bp_fired    = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural calculator: done is a level held until the next start
  // (optionally for one extra cycle), result after LAT cycles.
  initial begin
    int          cnt;
    bit          active;
    logic [10:0] cx, cy;
    cnt = 0; active = 0; cx = '0; cy = '0;
    bus_if.calc_done  = 1'b0;
    bus_if.calc_depth = '0;
    forever begin
      @(negedge sysclk);
      if (reset) begin
        bus_if.calc_done  = 1'b0;
        bus_if.calc_depth = '0;
        active = 0;
      end else if (bus_if.calc_start) begin
        active = 1; cnt = 0;
        cx = bus_if.calc_x; cy = bus_if.calc_y;
        if (!stale_hold) bus_if.calc_done = 1'b0;
      end else if (active) begin
        cnt++;
        if (cnt == 2) bus_if.calc_done = 1'b0;
        if (cnt == LAT) begin
          bus_if.calc_depth = 10'(cx + 4 * cy);
          bus_if.calc_done  = 1'b1;
          active = 0;
        end
      end
    end
  end

  // Issue monitor: checks each issued pixel and pushes its expected output.
  initial begin
    forever begin
      @(negedge sysclk);
      if (!reset && bus_if.calc_start) begin
        logic [10:0] ex, ey;
        logic [63:0] ere, eim;
        exp_pix_t    e;
        ex  = 11'(issue_idx % HR);
        ey  = 11'(issue_idx / HR);
        ere = exp_re0 + 64'(ex) * exp_step;
        eim = exp_im0 - 64'(ey) * exp_step;
        if (issue_idx >= NPIX) chk("issue_count", 64'(issue_idx), 64'(NPIX - 1));
        chk("calc_x", bus_if.calc_x, ex);
        chk("calc_y", bus_if.calc_y, ey);
        chk("re_c", bus_if.re_c, ere);
        chk("im_c", bus_if.im_c, eim);
        if (wrap_mode && ex == 11'd1) chk("wrap_re_x1", bus_if.re_c, MINN);
        e.x     = ex;
        e.y     = ey;
        e.depth = 10'(ex + 4 * ey);
        e.sof   = (ex == 0) && (ey == 0);
        e.eol   = (ex == 11'(HR - 1));
        sb.push_back(e);
        issue_idx++;
        issue_total++;
      end
    end
  end

  // Output monitor: pops on handshake, checks data holds while stalled.
  initial begin
    exp_pix_t e, cur, hold;
    bit       stalled;
    stalled = 0; hold = '0;
    forever begin
      @(negedge sysclk);
      cur.x     = bus_if.pix_x;
      cur.y     = bus_if.pix_y;
      cur.depth = bus_if.pix_depth;
      cur.sof   = bus_if.pix_sof;
      cur.eol   = bus_if.pix_eol;
      if (reset) begin
        stalled = 0;
      end else begin
        if (stalled) begin
          chk("stall_valid", bus_if.pix_valid, 1'b1);
          chk("stall_data", 64'(cur), 64'(hold));
        end
        if (bus_if.pix_valid && bus_if.pix_ready) begin
          if (sb.size() == 0) begin
            chk("pix_unexpected", 64'(sb.size()), 64'd1);
          end else begin
            e = sb.pop_front();
            chk("pix_x", cur.x, e.x);
            chk("pix_y", cur.y, e.y);
            chk("pix_depth", cur.depth, e.depth);
            chk("pix_sof", cur.sof, e.sof);
            chk("pix_eol", cur.eol, e.eol);
          end
          n_out++;
        end
        stalled = bus_if.pix_valid && !bus_if.pix_ready;
        hold    = cur;
      end
    end
  end

  // frame_done monitor.
  initial begin
    forever begin
      @(negedge sysclk);
      if (!reset && bus_if.frame_done) begin
        n_fdone++;
        chk("busy_at_frame_done", bus_if.busy, 1'b0);
      end
    end
  end

  // pix_ready driver: one 5-cycle backpressure window on pixel (2,1).
  initial begin
    int s0;
    bus_if.pix_ready = 1'b1;
    forever begin
      @(posedge sysclk); #1;
      if (bp_arm && !bp_fired && !reset && bus_if.pix_valid &&
          bus_if.pix_x == 11'd2 && bus_if.pix_y == 11'd1) begin
        bus_if.pix_ready = 1'b0;
        s0 = issue_total;
        repeat (5) @(posedge sysclk);
        #1;
        chk("bp_new_calc_starts", 64'(issue_total - s0), 64'(BP_STARTS));
        bus_if.pix_ready = 1'b1;
        bp_fired = 1;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_calc_start"}, bus_if.calc_start, 1'b0);
    chk({tag, "_calc_x"}, bus_if.calc_x, 11'd0);
    chk({tag, "_calc_y"}, bus_if.calc_y, 11'd0);
    chk({tag, "_re_c"}, bus_if.re_c, 64'd0);
    chk({tag, "_im_c"}, bus_if.im_c, 64'd0);
    chk({tag, "_pix_valid"}, bus_if.pix_valid, 1'b0);
    chk({tag, "_pix_depth"}, bus_if.pix_depth, 10'd0);
    chk({tag, "_pix_x"}, bus_if.pix_x, 11'd0);
    chk({tag, "_pix_y"}, bus_if.pix_y, 11'd0);
    chk({tag, "_pix_sof_eol"}, {bus_if.pix_sof, bus_if.pix_eol}, 2'b00);
    chk({tag, "_busy"}, bus_if.busy, 1'b0);
    chk({tag, "_frame_done"}, bus_if.frame_done, 1'b0);
  endtask

  // Pulse frame_start for one cycle; the first calc_start must follow.
  task automatic start_frame(input logic [63:0] re0, input logic [63:0] im0,
                             input logic [63:0] st);
    exp_re0 = re0; exp_im0 = im0; exp_step = st;
    issue_idx = 0;
    bus_if.re_origin   = re0;
    bus_if.im_origin   = im0;
    bus_if.step        = st;
    bus_if.frame_start = 1'b1;
    @(posedge sysclk); #1;
    bus_if.frame_start = 1'b0;
    chk("start_calc_start", bus_if.calc_start, 1'b1);
    chk("start_busy", bus_if.busy, 1'b1);
  endtask

  // Wait (bounded) for frame_done, then check the whole frame was delivered.
  // Returns inside the frame_done cycle.
  task automatic finish_frame(input string tag, input int out0, input int fd0);
    bit seen;
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge sysclk); #1;
      if (bus_if.frame_done) begin
        seen = 1;
        break;
      end
    end
    chk({tag, "_frame_done_seen"}, 64'(seen), 64'd1);
    @(negedge sysclk); #1;
    chk({tag, "_pixels_out"}, 64'(n_out - out0), 64'(NPIX));
    chk({tag, "_frame_done_count"}, 64'(n_fdone - fd0), 64'd1);
    chk({tag, "_issued"}, 64'(issue_idx), 64'(NPIX));
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    chk({tag, "_busy_low"}, bus_if.busy, 1'b0);
  endtask

  task automatic wait_issue(input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge sysclk); #1;
      if (issue_idx >= n) begin
        ok = 1;
        break;
      end
    end
    chk("wait_issue_reached", 64'(ok), 64'd1);
  endtask

  initial begin
    int out0, fd0;
    bus_if.frame_start = 1'b0;
    bus_if.re_origin   = '0;
    bus_if.im_origin   = '0;
    bus_if.step        = '0;
    exp_re0 = '0; exp_im0 = '0; exp_step = '0;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    @(posedge sysclk); #1;
    check_zero("idle");

    // Basic raster
    out0 = n_out; fd0 = n_fdone;
    start_frame(NEG2, ONE, HALF);
    finish_frame("basic", out0, fd0);

    // Stale done, started in the frame_done cycle of the previous frame
    stale_hold = 1;
    out0 = n_out; fd0 = n_fdone;
    start_frame(NEG2, ONE, HALF);
    finish_frame("stale", out0, fd0);
    stale_hold = 0;

    // Backpressure on pixel (2,1)
    bp_arm = 1;
    out0 = n_out; fd0 = n_fdone;
    start_frame(NEG2, ONE, HALF);
    finish_frame("bp", out0, fd0);
    chk("bp_window_hit", 64'(bp_fired), 64'd1);
    bp_arm = 0;

    // frame_start while busy is ignored
    out0 = n_out; fd0 = n_fdone;
    start_frame(HALF, NEG2, ONE);
    wait_issue(3);
    bus_if.re_origin   = 64'd0;
    bus_if.im_origin   = 64'd0;
    bus_if.step        = 64'h0400_0000_0000_0000;
    bus_if.frame_start = 1'b1;
    @(posedge sysclk); #1;
    bus_if.frame_start = 1'b0;
    chk("ignore_busy_high", bus_if.busy, 1'b1);
    finish_frame("ignore", out0, fd0);

    // Reset during WAIT of pixel (1,0)
    start_frame(NEG2, ONE, HALF);
    wait_issue(2);
    reset = 1'b1;
    #1;
    check_zero("midrst");
    @(posedge sysclk); #1;
    reset = 1'b0;
    sb.delete();
    @(posedge sysclk); #1;
    check_zero("after_rst");
    out0 = n_out; fd0 = n_fdone;
    start_frame(NEG2, ONE, HALF);
    finish_frame("restart", out0, fd0);

    // Real accumulator wrap
    wrap_mode = 1;
    out0 = n_out; fd0 = n_fdone;
    start_frame(MAXP, 64'd0, 64'd1);
    finish_frame("wrap", out0, fd0);
    wrap_mode = 0;

    repeat (3) @(posedge sysclk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
